// File: rtl/sram_access_ctrl.sv
// Byte-addressed load/store front end for a single-port word SRAM. Partial-word
// stores are turned into a read-modify-write so the SRAM only ever sees full words.
module sram_access_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_write_data,
  input  logic [DATA_W-1:0] sram_read_data
);

  typedef enum logic [2:0] {StIdle, StRead, StRmw, StWrite, StResp} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;

  assign accept = req_valid && (state_q == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_addr[1:0] != 2'b00) begin
            state_d = StResp;
          end else if (!req_we) begin
            state_d = StRead;
          end else if (req_be == 4'hF) begin
            state_d = StWrite;
          end else if (req_be == 4'h0) begin
            state_d = StResp;
          end else begin
            state_d = StRmw;
          end
        end
      end
      StRead:  state_d = StResp;
      StRmw:   state_d = StWrite;
      StWrite: state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers; word_q is the word handed to the SRAM in WRITE.
  always_comb begin
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      addr_d  = req_addr[ADDR_W+1:2];
      be_d    = req_be;
      wdata_d = req_wdata;
      word_d  = req_wdata;
      rdata_d = '0;
      err_d   = (req_addr[1:0] != 2'b00);
    end
    if (state_q == StRead) begin
      rdata_d = sram_read_data;
    end
    if (state_q == StRmw) begin
      for (int unsigned i = 0; i < 4; i++) begin
        word_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : sram_read_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    sram_w_en = (state_q == StWrite);
  end

  assign rsp_rdata       = rdata_q;
  assign rsp_err         = err_q;
  assign sram_address    = addr_q;
  assign sram_write_data = word_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl: a behavioural SRAM, a driver that queues
// expected responses, and a negedge monitor that checks responses and latency.
module tb_sram_access_ctrl;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  logic [31:0] mem [0:65535];
  int          wcnt = 0;
  logic [15:0] last_waddr = '0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        prev_v = 1'b0;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];

  always #5 clk = ~clk;

  sram_access_ctrl #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_be          (req_be),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .sram_w_en       (sram_w_en),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data)
  );

  assign sram_read_data = mem[sram_address];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (sram_w_en) begin
      mem[sram_address] <= sram_write_data;
      wcnt              <= wcnt + 1;
      last_waddr        <= sram_address;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Latency is counted from the handshake cycle to the first cycle with rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid && !prev_v) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 want no response");
      end else begin
        check("latency", cyc - acc_cyc, q[0].lat);
      end
    end
    if (rsp_valid && rsp_ready && q.size() > 0) begin
      e = q.pop_front();
      check("rsp_rdata", rsp_rdata, e.rdata);
      check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
    end
    prev_v = rsp_valid;
    if (req_valid && req_ready) acc_cyc = cyc;
  end

  task automatic do_req(input logic we, input logic [17:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input bit push, input logic [31:0] er,
                        input logic ee, input int el);
    bit ok;
    @(posedge clk);
    #1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    req_valid = 1'b1;
    if (push) q.push_back(exp_t'{rdata: er, err: ee, lat: el});
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=0 want 1");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL drain_timeout: got pending=%0d want 0", q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    check({tag, "_sram_w_en"}, {31'b0, sram_w_en}, 32'd0);
    check({tag, "_sram_address"}, {16'b0, sram_address}, 32'd0);
    check({tag, "_sram_write_data"}, sram_write_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[1] = 32'hDEADBEEF;
    mem[2] = 32'h11223344;
    mem[8] = 32'hCAFEF00D;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Load from word 1.
    w0 = wcnt;
    do_req(1'b0, 18'h4, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2);
    drain();
    check("load_no_write", wcnt, w0);

    // Full store then load-back.
    do_req(1'b1, 18'h10, 32'h12345678, 4'hF, 1'b1, 32'h0, 1'b0, 2);
    drain();
    check("full_store_pulses", wcnt, w0 + 1);
    check("full_store_addr", {16'b0, last_waddr}, 32'd4);
    check("full_store_mem", mem[4], 32'h12345678);
    do_req(1'b0, 18'h10, 32'h0, 4'h0, 1'b1, 32'h12345678, 1'b0, 2);
    drain();

    // Partial store merges lanes 0 and 2.
    do_req(1'b1, 18'h8, 32'hAABBCCDD, 4'b0101, 1'b1, 32'h0, 1'b0, 3);
    drain();
    check("rmw_mem", mem[2], 32'h11BB33DD);

    // Misaligned accesses and an empty-enable store never touch the SRAM.
    w0 = wcnt;
    do_req(1'b0, 18'h3, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1, 1);
    drain();
    do_req(1'b1, 18'h6, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0, 1'b1, 1);
    drain();
    do_req(1'b1, 18'h4, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0, 1'b0, 1);
    drain();
    check("no_write_count", wcnt, w0);
    check("be0_mem", mem[1], 32'hDEADBEEF);

    // Response back-pressure with a second request waiting.
    rsp_ready = 1'b0;
    do_req(1'b0, 18'h4, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2);
    req_we    = 1'b0;
    req_addr  = 18'h10;
    req_be    = 4'h0;
    req_valid = 1'b1;
    q.push_back(exp_t'{rdata: 32'h12345678, err: 1'b0, lat: 2});
    @(posedge clk);
    #1;
    repeat (5) begin
      @(negedge clk);
      check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("hold_req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("accept_after_hs", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    drain();

    // Reset during WRITE of a partial store must not commit.
    w0 = wcnt;
    do_req(1'b1, 18'h20, 32'hFFFFFFFF, 4'b0011, 1'b0, 32'h0, 1'b0, 0);
    @(posedge clk);
    #1;
    check("write_cycle_w_en", {31'b0, sram_w_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_mem", mem[8], 32'hCAFEF00D);
    check("midrst_wcnt", wcnt, w0);
    check("midrst_ready_after", {31'b0, req_ready}, 32'd1);
    check("midrst_no_rsp", {31'b0, rsp_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_access_ctrl.md
# sram_access_ctrl

Request/response front end that sits directly upstream of the 64K×32 word SRAM and is its only driver. It accepts byte-addressed load/store requests from the core's load/store unit over a valid/ready handshake and converts them into SRAM word accesses. Partial-word (byte-enable) stores become a read-modify-write sequence, because the SRAM only writes full words. Results return on a separate valid/ready response channel.

## Interface
- `ADDR_W`, 16, SRAM word-address width; the byte address is `ADDR_W+2` bits.
- `DATA_W`, 32, data width; fixed at 32 because byte enables assume 4 lanes.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W+2  byte address.
- `req_wdata`  in  32  store data, little-endian lanes.
- `req_be`  in  4  byte enables; bit i selects bits [8i+7:8i].
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned request.
- `sram_w_en`  out  1  SRAM write enable.
- `sram_address`  out  ADDR_W  SRAM word address.
- `sram_write_data`  out  32  SRAM write data.
- `sram_read_data`  in  32  combinational SRAM read data.

## Operation
- States: IDLE, READ, RMW, WRITE, RESP.
- IDLE:
  - `req_ready`=1 only in IDLE.
  - On `req_valid & req_ready`, latch `we`, `be`, `wdata`, and the word address `req_addr[ADDR_W+1:2]`.
- Transitions out of IDLE:
  - `req_addr[1:0]`≠0 → RESP with err=1. No SRAM access, no write.
  - Load → READ.
  - Store with be=4'hF → WRITE; the write data is wdata.
  - Store with be=4'h0 → RESP with err=0. No SRAM access.
  - Store with any other be → RMW.
- READ: capture `sram_read_data` into the response register → RESP.
- RMW: merge into an internal word register. Lanes with be=1 take wdata; other lanes take `sram_read_data`. → WRITE.
- WRITE:
  - `sram_w_en`=1 for exactly this one cycle.
  - `sram_write_data` = merged word (or wdata for a full store).
  - → RESP.
- RESP:
  - `rsp_valid`=1, with `rsp_rdata`/`rsp_err` held stable until `rsp_ready`=1.
  - On `rsp_ready`=1 → IDLE.
- `sram_address` is driven from the latched word-address register in every state.
- `sram_w_en` is decoded combinationally from state; it is 1 only in WRITE.
- One transaction in flight at a time; no new request is accepted until the response is taken.

## Timing
- Reset values:
  - state=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `sram_w_en`=0, `sram_address`=0, `sram_write_data`=0.
- Latency, with acceptance on edge N (rsp_valid rising after that edge):
  - Misaligned or be=0: `rsp_valid` high after N+1.
  - Load: READ in cycle N+1, `rsp_valid` after N+2.
  - Full store: WRITE in cycle N+1 (SRAM updates at edge N+2), `rsp_valid` after N+2.
  - Partial store: RMW in N+1, WRITE in N+2, `rsp_valid` after N+3.
- Back-to-back throughput:
  - RESP→IDLE on the `rsp_ready` edge; the next request is accepted one cycle later.
  - A request asserted during RESP waits (`req_ready`=0) with its fields held by the producer.
- `rsp_ready` held low: response is held indefinitely; no SRAM activity.
- Load after store to the same word returns the stored data, because the write completes before RESP.
- Reset mid-operation:
  - Asserting `rst_n` low forces IDLE immediately.
  - `sram_w_en` drops asynchronously, so a WRITE in progress is not committed at the next edge.
  - Any pending response is discarded.
- The highest word address `{ADDR_W{1'b1}}` is legal; there is no wrap logic, since the word address is a direct slice of the byte address.

## Test plan
- Reset, then load from 0x0004 with the SRAM preloaded mem[1]=32'hDEADBEEF → `rsp_valid` two cycles after acceptance, `rsp_rdata`=32'hDEADBEEF, `rsp_err`=0, `sram_w_en` never high.
- Full store of 32'h12345678, be=4'hF, to 0x0010, then load 0x0010 → one `sram_w_en` pulse with address 4; the load returns 32'h12345678.
- Partial store of 32'hAABBCCDD, be=4'b0101, to 0x0008 with mem[2]=32'h11223344 → mem[2]=32'h11BB33DD; `rsp_valid` three cycles after acceptance.
- Misaligned load at 0x0003 and store at 0x0006 → `rsp_err`=1, `rsp_rdata`=0, no SRAM write, `rsp_valid` one cycle after acceptance.
- `rsp_ready` held low for 5 cycles after a load, with a second request pending → `rsp_valid`/`rsp_rdata` stable and `req_ready`=0 throughout; the second request is accepted the cycle after the handshake.
- `rst_n` pulsed low during the WRITE cycle of a partial store to 0x0020 → mem[8] unchanged, all outputs at reset values, `req_ready`=1 after release.
